ws2812_frame_driver: RTL

- Parametrised WS2812-family serial LED driver. Streams a frame of NLEDS pixels from an external synchronous pixel RAM (1-cycle read latency) onto a single GPIO data line.
- Adds to the fixed-pattern generator of the previous generation:
  - start/busy/done handshake
  - global brightness scaling
  - selectable colour order
  - optional RGBW (32-bit) pixels
  - exact, parameter-set bit timing
- Sits between a pixel framebuffer (written by a CPU or pattern generator) and the LED strip pin.

---
 rtl/ws2812_frame_driver_if.sv | 33 +++
 rtl/ws2812_frame_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_driver_if.sv
// Host-side bundle for the WS2812 frame driver: start/busy/done handshake,
// per-frame settings and the read port of the external pixel RAM.
interface ws2812_frame_driver_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic              busy;
    logic              done;
    logic [7:0]        brightness;
    logic              order;
    logic [ADDR_W-1:0] pix_addr;
    logic [31:0]       pix_data;

    modport master (
        output start,
        output brightness,
        output order,
        output pix_data,
        input  busy,
        input  done,
        input  pix_addr
    );

    modport slave (
        input  start,
        input  brightness,
        input  order,
        input  pix_data,
        output busy,
        output done,
        output pix_addr
    );
endinterface

// File: rtl/ws2812_frame_driver.sv
// WS2812-family strip driver: streams NLEDS pixels from a 1-cycle-latency pixel RAM onto
// one data line, with per-frame brightness/colour order and gapless next-pixel prefetch.
module ws2812_frame_driver #(
    parameter int unsigned NLEDS  = 64,
    parameter int unsigned RGBW   = 0,
    parameter int unsigned T0H    = 18,
    parameter int unsigned T0L    = 40,
    parameter int unsigned T1H    = 35,
    parameter int unsigned T1L    = 30,
    parameter int unsigned TRESET = 3000,
    parameter int unsigned ADDR_W = (NLEDS > 1) ? $clog2(NLEDS) : 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    ws2812_frame_driver_if.slave bus,
    output logic                 GPIO
);
    localparam int unsigned BPP       = (RGBW != 0) ? 32 : 24;
    localparam int unsigned BIT_W     = $clog2(BPP);
    localparam int unsigned T_HI_MAX  = (T0H > T1H) ? T0H : T1H;
    localparam int unsigned T_LO_MAX  = (T0L > T1L) ? T0L : T1L;
    localparam int unsigned T_BIT_MAX = (T_HI_MAX > T_LO_MAX) ? T_HI_MAX : T_LO_MAX;
    localparam int unsigned T_MAX     = (TRESET > T_BIT_MAX) ? TRESET : T_BIT_MAX;
    localparam int unsigned TMR_W     = $clog2(T_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NLEDS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(BPP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetchAddr,
        StFetchData,
        StHigh,
        StLow,
        StLatch
    } state_e;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BPP-1:0]    shift_q, shift_d;
    logic [BPP-1:0]    shadow_q, shadow_d;
    logic [7:0]        bright_q, bright_d;
    logic              order_q, order_d;
    logic              gpio_q;

    logic              enter_pixel;
    logic [TMR_W-1:0]  high_end;
    logic [TMR_W-1:0]  low_end;

    // (c * (brightness + 1)) >> 8 keeps brightness 255 as identity and 0 as black.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
        return 8'((16'(c) * (16'(br) + 16'd1)) >> 8);
    endfunction

    // Scales all channels and arranges them in wire order, first bit at the MSB.
    function automatic logic [BPP-1:0] pack_pixel(input logic [31:0] raw,
                                                  input logic [7:0]  br,
                                                  input logic        ord);
        logic [7:0]  w, r, g, b;
        logic [31:0] word;
        w    = scale(raw[31:24], br);
        r    = scale(raw[23:16], br);
        g    = scale(raw[15:8], br);
        b    = scale(raw[7:0], br);
        word = ord ? {r, g, b, w} : {g, r, b, w};
        return word[31 -: BPP];
    endfunction

    assign high_end = shift_q[BPP-1] ? TMR_W'(T1H - 1) : TMR_W'(T0H - 1);
    assign low_end  = shift_q[BPP-1] ? TMR_W'(T1L - 1) : TMR_W'(T0L - 1);

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q + TMR_W'(1);
        bit_d       = bit_q;
        pix_d       = pix_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        shadow_d    = shadow_q;
        bright_d    = bright_q;
        order_d     = order_q;
        enter_pixel = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmr_d = '0;
                if (bus.start) begin
                    state_d  = StFetchAddr;
                    bright_d = bus.brightness;
                    order_d  = bus.order;
                    addr_d   = '0;
                    pix_d    = '0;
                end
            end
            StFetchAddr: begin
                state_d = StFetchData;
            end
            StFetchData: begin
                state_d     = StHigh;
                tmr_d       = '0;
                bit_d       = '0;
                shift_d     = pack_pixel(bus.pix_data, bright_q, order_q);
                enter_pixel = 1'b1;
            end
            StHigh: begin
                // Prefetched address went out on the first HIGH cycle; data lands one cycle later.
                if (bit_q == '0 && tmr_q == TMR_W'(1) && pix_q != LAST_PIX) begin
                    shadow_d = pack_pixel(bus.pix_data, bright_q, order_q);
                end
                if (tmr_q == high_end) begin
                    state_d = StLow;
                    tmr_d   = '0;
                end
            end
            StLow: begin
                if (tmr_q == low_end) begin
                    tmr_d = '0;
                    if (bit_q != LAST_BIT) begin
                        state_d = StHigh;
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {shift_q[BPP-2:0], 1'b0};
                    end else if (pix_q != LAST_PIX) begin
                        state_d     = StHigh;
                        bit_d       = '0;
                        pix_d       = pix_q + ADDR_W'(1);
                        shift_d     = shadow_q;
                        enter_pixel = 1'b1;
                    end else begin
                        state_d = StLatch;
                    end
                end
            end
            StLatch: begin
                if (tmr_q == TMR_W'(TRESET - 1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (enter_pixel && pix_d != LAST_PIX) begin
            addr_d = pix_d + ADDR_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= StIdle;
            tmr_q    <= '0;
            bit_q    <= '0;
            pix_q    <= '0;
            addr_q   <= '0;
            shift_q  <= '0;
            shadow_q <= '0;
            bright_q <= '0;
            order_q  <= 1'b0;
            gpio_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            pix_q    <= pix_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            shadow_q <= shadow_d;
            bright_q <= bright_d;
            order_q  <= order_d;
            gpio_q   <= (state_d == StHigh);
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StLatch) && (tmr_q == TMR_W'(TRESET - 1));
    assign bus.pix_addr = addr_q;
    assign GPIO         = gpio_q;
endmodule
